issue_ctrl: RTL and testbench
=============================

# issue_ctrl

In-order issue controller for the simple CPU. It sits between instruction decode and the execute units, accepts one 32-bit instruction per cycle over a valid/ready handshake, and tracks register hazards with a 32-entry busy scoreboard. It sequences single-cycle ALU ops, the shared non-pipelined MUL/DIV unit, one outstanding memory op and one unresolved branch, stalling the instruction stream whenever a hazard or structural conflict exists.

## Interface
- MUL_LAT, 3, MUL cycles from handshake to writeback strobe (≥2)
- DIV_LAT, 8, DIV cycles from handshake to writeback strobe (≥2)
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- instr_i  in  32  instruction: offset[31:19], ra[18:14], rb[13:9], rd[8:4], opcode[3:0]; opcodes per opcode.svh
- instr_valid_i  in  1  instr_i valid
- instr_ready_o  out  1  controller accepts instr_i this cycle (combinational)
- issue_valid_o  out  1  registered issue strobe
- issue_instr_o  out  32  issued instruction
- unit_sel_o  out  2  0 ALU, 1 MULDIV, 2 MEM, 3 BRANCH
- wb_en_o  out  1  MUL/DIV result writeback strobe
- wb_rd_o  out  5  MUL/DIV destination register
- mem_done_i  in  1  outstanding LW/SW complete
- branch_done_i  in  1  outstanding branch resolved
- busy_o  out  32  scoreboard; bit 0 always 0

## Operation
- Class and register use:
  - ADD/SUB/AND/OR/XOR: ALU; reads ra, rb; writes rd.
  - ADDI: ALU; reads ra; writes rd.
  - MUL/DIV: MULDIV; reads ra, rb; writes rd.
  - LW: MEM; reads ra; writes rb.
  - SW: MEM; reads ra, rb.
  - BEQ/BGT/BGE: BRANCH; reads ra, rb.
  - Unknown opcode: ALU class, no register use; always issuable when in RUN.
- Register 0 is never marked busy and never causes a hazard.
- ALU ops never set busy bits, because the result is available to the next instruction.
- Handshake occurs when instr_valid_i && instr_ready_o. instr_ready_o is high only when all of the following hold:
  - state is RUN;
  - no source register is busy (RAW);
  - the destination register is not busy (WAW);
  - for MUL/DIV: the MUL/DIV unit is idle;
  - for LW/SW: no memory op is outstanding.
- Handshake on MUL/DIV:
  - sets busy[rd];
  - loads the countdown with MUL_LAT or DIV_LAT;
  - marks the unit busy.
- Handshake on LW sets busy[rb]. Handshake on LW or SW sets mem_outstanding.
- Handshake on a branch moves the FSM from RUN to BR_WAIT.
- FSM:
  - RUN → BR_WAIT on branch handshake.
  - BR_WAIT → RUN on branch_done_i.
  - branch_done_i is ignored in RUN.
- mem_done_i is ignored when no memory op is outstanding. When a memory op is outstanding, it clears mem_outstanding and, for LW, the busy bit of the destination.
- MUL/DIV completion and mem_done_i in the same cycle are independent: both busy bits clear.
- A busy bit being cleared in a cycle still blocks that cycle; there is no bypass.
- Reset (rst_i low at an edge):
  - state RUN;
  - busy_o = 0, countdown = 0, mem_outstanding = 0;
  - all outputs 0, including instr_ready_o while rst_i is low;
  - in-flight ops are discarded, so no wb_en_o follows.

## Timing
- Handshake in cycle t → issue_valid_o, issue_instr_o, unit_sel_o valid in cycle t+1 for exactly one cycle. Otherwise issue_valid_o is 0 and issue_instr_o holds its last value.
- Busy bits set by a handshake in t are visible on busy_o from t+1.
- MUL handshake in t:
  - wb_en_o = 1 and wb_rd_o = rd in cycle t+MUL_LAT only;
  - busy[rd] is clear and the unit is idle from t+MUL_LAT+1;
  - the earliest dependent or next MUL/DIV handshake is at t+MUL_LAT+1.
- DIV follows the same rules with DIV_LAT.
- mem_done_i in cycle u:
  - busy/outstanding clear from u+1;
  - the earliest dependent or next memory handshake is at u+1.
- branch_done_i in cycle u (in BR_WAIT): RUN from u+1, and instr_ready_o may assert in u+1.
- Throughput: one instruction per cycle for independent ALU ops.
- wb_rd_o holds its value when wb_en_o is 0. Reset value of wb_rd_o is 0.

## Test plan
- Reset: hold rst_i low 2 cycles with instr_valid_i=1 → instr_ready_o=0, issue_valid_o=0, wb_en_o=0, busy_o=0; after release, first ADD handshakes in the first cycle with rst_i high.
- Back-to-back ADD r1,r1→r3; ADD r1,r3→r22; ADD r1,r22→r23 → handshakes in cycles 0,1,2; issue_valid_o high in 1,2,3 with unit_sel_o=0.
- MUL r6,r7→r8 (MUL_LAT=3) at t=0, then ADD r8,r1→r9 → busy_o[8]=1 in cycles 1–3; wb_en_o=1, wb_rd_o=8 in cycle 3; ADD handshakes at cycle 4.
- DIV r9,r10→r11 (DIV_LAT=8) at t=0, then independent MUL r6,r7→r8 → MUL stalls; wb_en_o with wb_rd_o=11 in cycle 8; MUL handshakes at 9.
- Memory and branch sequence:
  - Stimulus: LW offset 15, base r0→r4 at t=0; SW r7 at t=1; mem_done_i in cycle 5; BEQ r4,r4 follows; branch_done_i 3 cycles later.
  - busy_o[4]=1 in cycles 1–5; SW handshakes at 6; BEQ issues once r4 is clear; instr_ready_o=0 throughout BR_WAIT and =1 the cycle after branch_done_i.
- Reset mid-MUL: MUL→r8 at t=0, rst_i low in cycle 1 → busy_o=0 from cycle 2, no wb_en_o ever; a stray mem_done_i after reset changes nothing.

Source files
------------

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue controller with register busy scoreboard
module issue_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic        issue_valid_o,
    output logic [31:0] issue_instr_o,
    output logic [1:0]  unit_sel_o,
    output logic        wb_en_o,
    output logic [4:0]  wb_rd_o,
    input  logic        mem_done_i,
    input  logic        branch_done_i,
    output logic [31:0] busy_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BGT  = 4'd11;
    localparam logic [3:0] OP_BGE  = 4'd12;

    localparam logic [1:0] SEL_ALU    = 2'd0;
    localparam logic [1:0] SEL_MULDIV = 2'd1;
    localparam logic [1:0] SEL_MEM    = 2'd2;
    localparam logic [1:0] SEL_BRANCH = 2'd3;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    state_t        state_q;
    logic [31:0]   busy_q;
    logic [31:0]   busy_nxt;
    logic [CW-1:0] cnt_q;
    logic [4:0]    md_rd_q;
    logic          mem_out_q;
    logic          mem_lw_q;
    logic [4:0]    mem_rd_q;

    logic [3:0] op;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rd;
    logic       use_ra;
    logic       use_rb;
    logic       dst_en;
    logic [4:0] dst;
    logic       dst_tracked;
    logic [1:0] cls;
    logic       is_md;
    logic       is_div;
    logic       is_mem;
    logic       is_lw;
    logic       is_br;
    logic       hazard;
    logic       md_busy;
    logic       ready;
    logic       hs;

    assign op = instr_i[3:0];
    assign rd = instr_i[8:4];
    assign rb = instr_i[13:9];
    assign ra = instr_i[18:14];

    always_comb begin
        use_ra = 1'b0;
        use_rb = 1'b0;
        dst_en = 1'b0;
        dst    = rd;
        cls    = SEL_ALU;
        is_md  = 1'b0;
        is_div = 1'b0;
        is_mem = 1'b0;
        is_lw  = 1'b0;
        is_br  = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                use_ra = 1'b1;
                use_rb = 1'b1;
                dst_en = 1'b1;
            end
            OP_ADDI: begin
                use_ra = 1'b1;
                dst_en = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                use_ra = 1'b1;
                use_rb = 1'b1;
                dst_en = 1'b1;
                cls    = SEL_MULDIV;
                is_md  = 1'b1;
                is_div = (op == OP_DIV);
            end
            OP_LW: begin
                use_ra = 1'b1;
                dst_en = 1'b1;
                dst    = rb;
                cls    = SEL_MEM;
                is_mem = 1'b1;
                is_lw  = 1'b1;
            end
            OP_SW: begin
                use_ra = 1'b1;
                use_rb = 1'b1;
                cls    = SEL_MEM;
                is_mem = 1'b1;
            end
            OP_BEQ, OP_BGT, OP_BGE: begin
                use_ra = 1'b1;
                use_rb = 1'b1;
                cls    = SEL_BRANCH;
                is_br  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // busy_q[0] is never set, so r0 can never produce a hazard here
    assign hazard = (use_ra && busy_q[ra]) ||
                    (use_rb && busy_q[rb]) ||
                    (dst_en && busy_q[dst]);

    assign md_busy = (cnt_q != '0);

    assign ready = rst_i && (state_q == RUN) && !hazard &&
                   !(is_md && md_busy) && !(is_mem && mem_out_q);

    assign hs            = instr_valid_i && ready;
    assign instr_ready_o = ready;
    assign busy_o        = busy_q;

    // ALU results forward, so only MUL/DIV and LW destinations are tracked
    assign dst_tracked = dst_en && (is_md || is_lw) && (dst != 5'd0);

    always_comb begin
        busy_nxt = busy_q;
        if (cnt_q == CW'(1)) begin
            busy_nxt[md_rd_q] = 1'b0;
        end
        if (mem_done_i && mem_out_q && mem_lw_q) begin
            busy_nxt[mem_rd_q] = 1'b0;
        end
        if (hs && dst_tracked) begin
            busy_nxt[dst] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= RUN;
            busy_q        <= '0;
            cnt_q         <= '0;
            md_rd_q       <= '0;
            mem_out_q     <= 1'b0;
            mem_lw_q      <= 1'b0;
            mem_rd_q      <= '0;
            issue_valid_o <= 1'b0;
            issue_instr_o <= '0;
            unit_sel_o    <= '0;
            wb_en_o       <= 1'b0;
            wb_rd_o       <= '0;
        end else begin
            busy_q        <= busy_nxt;
            issue_valid_o <= hs;
            if (hs) begin
                issue_instr_o <= instr_i;
                unit_sel_o    <= cls;
            end

            // Strobe one cycle before the count expires so wb_en_o lands on t+LAT
            wb_en_o <= (cnt_q == CW'(2));
            if (cnt_q == CW'(2)) begin
                wb_rd_o <= md_rd_q;
            end

            if (hs && is_md) begin
                cnt_q   <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
                md_rd_q <= dst;
            end else if (md_busy) begin
                cnt_q <= cnt_q - CW'(1);
            end

            if (hs && is_mem) begin
                mem_out_q <= 1'b1;
                mem_lw_q  <= is_lw;
                mem_rd_q  <= dst;
            end else if (mem_done_i && mem_out_q) begin
                mem_out_q <= 1'b0;
                mem_lw_q  <= 1'b0;
            end

            case (state_q)
                RUN: begin
                    if (hs && is_br) begin
                        state_q <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (branch_done_i) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed self-checking bench for issue_ctrl
module tb_issue_ctrl;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd6;
    localparam logic [3:0] OP_DIV = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd9;
    localparam logic [3:0] OP_BEQ = 4'd10;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        issue_valid_o;
    logic [31:0] issue_instr_o;
    logic [1:0]  unit_sel_o;
    logic        wb_en_o;
    logic [4:0]  wb_rd_o;
    logic        mem_done_i;
    logic        branch_done_i;
    logic [31:0] busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    issue_ctrl #(.MUL_LAT(3), .DIV_LAT(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .issue_valid_o (issue_valid_o),
        .issue_instr_o (issue_instr_o),
        .unit_sel_o    (unit_sel_o),
        .wb_en_o       (wb_en_o),
        .wb_rd_o       (wb_rd_o),
        .mem_done_i    (mem_done_i),
        .branch_done_i (branch_done_i),
        .busy_o        (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] ra,
                                        input logic [4:0] rb, input logic [4:0] rd,
                                        input logic [12:0] off);
        return {off, ra, rb, rd, op};
    endfunction

    // Drive a cycle's inputs just after the rising edge, then settle at the falling edge
    task automatic cyc(input logic r, input logic v, input logic [31:0] ins,
                       input logic md, input logic bd);
        @(posedge clk);
        #1;
        rst_i         = r;
        instr_valid_i = v;
        instr_i       = ins;
        mem_done_i    = md;
        branch_done_i = bd;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] i1, i2, i3, m, a, d, m2, l, s, b, x;
        i1 = enc(OP_ADD, 5'd1, 5'd1, 5'd3, 13'd0);
        i2 = enc(OP_ADD, 5'd1, 5'd3, 5'd22, 13'd0);
        i3 = enc(OP_ADD, 5'd1, 5'd22, 5'd23, 13'd0);
        m  = enc(OP_MUL, 5'd6, 5'd7, 5'd8, 13'd0);
        a  = enc(OP_ADD, 5'd8, 5'd1, 5'd9, 13'd0);
        d  = enc(OP_DIV, 5'd9, 5'd10, 5'd11, 13'd0);
        m2 = enc(OP_MUL, 5'd6, 5'd7, 5'd8, 13'd0);
        l  = enc(OP_LW, 5'd0, 5'd4, 5'd0, 13'd15);
        s  = enc(OP_SW, 5'd0, 5'd7, 5'd0, 13'd0);
        b  = enc(OP_BEQ, 5'd4, 5'd4, 5'd0, 13'd0);
        x  = enc(OP_ADD, 5'd1, 5'd2, 5'd5, 13'd0);

        rst_i         = 1'b0;
        instr_valid_i = 1'b1;
        instr_i       = i1;
        mem_done_i    = 1'b0;
        branch_done_i = 1'b0;

        // reset with a valid instruction pending
        for (int c = 0; c < 2; c++) begin
            cyc(1'b0, 1'b1, i1, 1'b0, 1'b0);
            check("rst_ready", instr_ready_o, 0);
            check("rst_issue_valid", issue_valid_o, 0);
            check("rst_wb_en", wb_en_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_wb_rd", wb_rd_o, 0);
        end

        // back-to-back independent ALU ops
        cyc(1'b1, 1'b1, i1, 1'b0, 1'b0);
        check("b2b_ready0", instr_ready_o, 1);
        cyc(1'b1, 1'b1, i2, 1'b0, 1'b0);
        check("b2b_ready1", instr_ready_o, 1);
        check("b2b_iv1", issue_valid_o, 1);
        check("b2b_instr1", issue_instr_o, i1);
        check("b2b_sel1", unit_sel_o, 0);
        cyc(1'b1, 1'b1, i3, 1'b0, 1'b0);
        check("b2b_ready2", instr_ready_o, 1);
        check("b2b_iv2", issue_valid_o, 1);
        check("b2b_instr2", issue_instr_o, i2);
        cyc(1'b1, 1'b0, i3, 1'b0, 1'b0);
        check("b2b_iv3", issue_valid_o, 1);
        check("b2b_instr3", issue_instr_o, i3);
        check("b2b_sel3", unit_sel_o, 0);

        // MUL then dependent ADD
        cyc(1'b1, 1'b1, m, 1'b0, 1'b0);
        check("mul_ready0", instr_ready_o, 1);
        check("mul_iv_idle", issue_valid_o, 0);
        check("mul_instr_hold", issue_instr_o, i3);
        for (int c = 1; c <= 3; c++) begin
            cyc(1'b1, 1'b1, a, 1'b0, 1'b0);
            check("mul_dep_stall", instr_ready_o, 0);
            check("mul_busy8", busy_o[8], 1);
            check("mul_wb_en", wb_en_o, (c == 3) ? 1 : 0);
            if (c == 1) begin
                check("mul_iv", issue_valid_o, 1);
                check("mul_sel", unit_sel_o, 1);
            end
            if (c == 3) check("mul_wb_rd", wb_rd_o, 8);
        end
        cyc(1'b1, 1'b1, a, 1'b0, 1'b0);
        check("mul_busy8_clr", busy_o[8], 0);
        check("mul_wb_off", wb_en_o, 0);
        check("mul_dep_ready", instr_ready_o, 1);

        // DIV blocks an independent MUL on the shared unit
        cyc(1'b1, 1'b1, d, 1'b0, 1'b0);
        check("div_ready0", instr_ready_o, 1);
        check("div_prev_instr", issue_instr_o, a);
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b1, 1'b1, m2, 1'b0, 1'b0);
            check("div_struct_stall", instr_ready_o, 0);
            check("div_busy11", busy_o[11], 1);
            check("div_wb_en", wb_en_o, (c == 8) ? 1 : 0);
            if (c == 8) check("div_wb_rd", wb_rd_o, 11);
        end
        cyc(1'b1, 1'b1, m2, 1'b0, 1'b0);
        check("div_mul_ready", instr_ready_o, 1);
        check("div_busy11_clr", busy_o[11], 0);
        for (int c = 10; c <= 13; c++) begin
            cyc(1'b1, 1'b0, m2, 1'b0, 1'b0);
            check("mul2_wb_en", wb_en_o, (c == 12) ? 1 : 0);
            if (c == 10) check("wb_rd_hold", wb_rd_o, 11);
            if (c == 12) check("mul2_wb_rd", wb_rd_o, 8);
        end
        check("mul2_busy_clr", busy_o, 0);

        // LW, SW behind the outstanding memory op, then a branch
        cyc(1'b1, 1'b1, l, 1'b0, 1'b0);
        check("lw_ready", instr_ready_o, 1);
        for (int c = 1; c <= 5; c++) begin
            cyc(1'b1, 1'b1, s, (c == 5), 1'b0);
            check("sw_stall", instr_ready_o, 0);
            check("lw_busy4", busy_o[4], 1);
            if (c == 1) check("lw_sel", unit_sel_o, 2);
        end
        cyc(1'b1, 1'b1, s, 1'b0, 1'b0);
        check("lw_busy4_clr", busy_o[4], 0);
        check("sw_ready", instr_ready_o, 1);
        cyc(1'b1, 1'b1, b, 1'b0, 1'b0);
        check("beq_ready", instr_ready_o, 1);
        check("sw_issued", issue_instr_o, s);
        for (int c = 8; c <= 10; c++) begin
            cyc(1'b1, 1'b1, x, 1'b0, (c == 10));
            check("br_wait_stall", instr_ready_o, 0);
            if (c == 8) check("beq_sel", unit_sel_o, 3);
        end
        cyc(1'b1, 1'b1, x, 1'b0, 1'b0);
        check("br_resume", instr_ready_o, 1);
        cyc(1'b1, 1'b0, x, 1'b1, 1'b0);
        check("br_resume_sel", unit_sel_o, 0);

        // reset while a MUL is in flight
        cyc(1'b1, 1'b1, m, 1'b0, 1'b0);
        check("rmul_ready", instr_ready_o, 1);
        cyc(1'b0, 1'b1, m, 1'b0, 1'b0);
        check("rmul_rst_ready", instr_ready_o, 0);
        check("rmul_busy8", busy_o[8], 1);
        for (int c = 2; c <= 7; c++) begin
            cyc(1'b1, 1'b0, m, (c == 3), 1'b0);
            check("rmul_busy_clr", busy_o, 0);
            check("rmul_no_wb", wb_en_o, 0);
        end
        cyc(1'b1, 1'b1, l, 1'b0, 1'b0);
        check("rmul_lw_ready", instr_ready_o, 1);
        cyc(1'b1, 1'b0, l, 1'b0, 1'b0);
        check("rmul_lw_busy4", busy_o, 32'h0000_0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
